// File: rtl/synth_pkg.sv
// Shared types, constants and saturating envelope arithmetic for the synth voice path.
// Arithmetic is done 33 bits wide so the envelope can never wrap.
package synth_pkg;

    localparam int SAMPLE_W = 32;
    localparam logic [SAMPLE_W-1:0] ENV_MAX = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    // A zero increment means "jump straight to full scale".
    function automatic logic [SAMPLE_W-1:0] env_add_sat(
        input logic [SAMPLE_W-1:0] env,
        input logic [SAMPLE_W-1:0] incr
    );
        logic [SAMPLE_W:0] sum_s;
        sum_s = {1'b0, env} + {1'b0, incr};
        if ((incr == 32'd0) || sum_s[SAMPLE_W]) begin
            return ENV_MAX;
        end else begin
            return sum_s[SAMPLE_W-1:0];
        end
    endfunction

    // A zero decrement means "jump straight to the floor".
    function automatic logic [SAMPLE_W-1:0] env_sub_floor(
        input logic [SAMPLE_W-1:0] env,
        input logic [SAMPLE_W-1:0] decr,
        input logic [SAMPLE_W-1:0] floor_level
    );
        logic [SAMPLE_W:0] diff_s;
        diff_s = {1'b0, env} - {1'b0, decr};
        if ((decr == 32'd0) || diff_s[SAMPLE_W] || (diff_s[SAMPLE_W-1:0] < floor_level)) begin
            return floor_level;
        end else begin
            return diff_s[SAMPLE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope: advances once per sample strobe and scales the
// oscillator sample by the pre-update envelope into a registered amplitude.
module adsr_envelope
    import synth_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                step_in,
    input  logic                gate_in,
    input  logic [SAMPLE_W-1:0] attack_incr,
    input  logic [SAMPLE_W-1:0] decay_decr,
    input  logic [SAMPLE_W-1:0] sustain_level,
    input  logic [SAMPLE_W-1:0] release_decr,
    input  logic [SAMPLE_W-1:0] amp_in,
    output logic [SAMPLE_W-1:0] amp_out,
    output logic                valid_out,
    output logic [SAMPLE_W-1:0] env_out,
    output logic                busy_out
);

    env_state_t          state_r;
    env_state_t          state_nxt_s;
    logic [SAMPLE_W-1:0] env_r;
    logic [SAMPLE_W-1:0] env_nxt_s;
    logic [SAMPLE_W-1:0] amp_r;
    logic [SAMPLE_W-1:0] amp_nxt_s;
    logic                valid_r;
    logic                busy_r;
    logic signed [2*SAMPLE_W:0] amp_ext_s;
    logic signed [2*SAMPLE_W:0] env_ext_s;
    logic signed [2*SAMPLE_W:0] product_s;

    // Next state and envelope; a low gate overrides the current segment's rate.
    always_comb begin
        state_nxt_s = state_r;
        env_nxt_s   = env_r;
        case (state_r)
            IDLE: begin
                if (gate_in) begin
                    env_nxt_s   = env_add_sat(32'd0, attack_incr);
                    state_nxt_s = (env_nxt_s == ENV_MAX) ? DECAY : ATTACK;
                end else begin
                    env_nxt_s   = 32'd0;
                    state_nxt_s = IDLE;
                end
            end
            ATTACK: begin
                if (!gate_in) begin
                    env_nxt_s   = env_sub_floor(env_r, release_decr, 32'd0);
                    state_nxt_s = RELEASE;
                end else begin
                    env_nxt_s   = env_add_sat(env_r, attack_incr);
                    state_nxt_s = (env_nxt_s == ENV_MAX) ? DECAY : ATTACK;
                end
            end
            DECAY: begin
                if (!gate_in) begin
                    env_nxt_s   = env_sub_floor(env_r, release_decr, 32'd0);
                    state_nxt_s = RELEASE;
                end else begin
                    env_nxt_s   = env_sub_floor(env_r, decay_decr, sustain_level);
                    state_nxt_s = (env_nxt_s == sustain_level) ? SUSTAIN : DECAY;
                end
            end
            SUSTAIN: begin
                if (!gate_in) begin
                    env_nxt_s   = env_sub_floor(env_r, release_decr, 32'd0);
                    state_nxt_s = RELEASE;
                end else begin
                    env_nxt_s   = sustain_level;
                    state_nxt_s = SUSTAIN;
                end
            end
            RELEASE: begin
                if (gate_in) begin
                    // Retrigger attacks from wherever the tail currently is.
                    env_nxt_s   = env_add_sat(env_r, attack_incr);
                    state_nxt_s = (env_nxt_s == ENV_MAX) ? DECAY : ATTACK;
                end else begin
                    env_nxt_s   = env_sub_floor(env_r, release_decr, 32'd0);
                    state_nxt_s = (env_nxt_s == 32'd0) ? IDLE : RELEASE;
                end
            end
            default: begin
                env_nxt_s   = 32'd0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Signed sample times zero-extended envelope; keep the top word (floor of /2^32).
    always_comb begin
        amp_ext_s = {{(SAMPLE_W+1){amp_in[SAMPLE_W-1]}}, amp_in};
        env_ext_s = {{(SAMPLE_W+1){1'b0}}, env_r};
        product_s = amp_ext_s * env_ext_s;
        amp_nxt_s = SAMPLE_W'(product_s >>> 7'd32);
    end

    // State, envelope and output registers advance only on the sample strobe.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= IDLE;
            env_r   <= 32'd0;
            amp_r   <= 32'd0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            valid_r <= step_in;
            if (step_in) begin
                state_r <= state_nxt_s;
                env_r   <= env_nxt_s;
                amp_r   <= amp_nxt_s;
                busy_r  <= (state_nxt_s != IDLE);
            end
        end
    end

    assign amp_out   = amp_r;
    assign valid_out = valid_r;
    assign env_out   = env_r;
    assign busy_out  = busy_r;

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Per-voice ADSR envelope stage that sits directly downstream of the triangle oscillator. It consumes the oscillator's signed 32-bit sample and the shared sample strobe, and advances an unsigned 32-bit envelope once per strobe through Attack/Decay/Sustain/Release. It outputs the sample scaled by the envelope, which is the voice amplitude fed to the mixer.

## Interface
Parameters:
- none; all rates and levels are run-time inputs.

Ports (all widths fixed):
- clk_in  input  1  system clock
- rst_in  input  1  reset; synchronous, active-high
- step_in  input  1  sample strobe, one-cycle pulse; same strobe that advances the oscillator phase
- gate_in  input  1  note held, level-sensitive; sampled only on step_in cycles
- attack_incr  input  32  unsigned; added to env per step in ATTACK
- decay_decr  input  32  unsigned; subtracted per step in DECAY
- sustain_level  input  32  unsigned target level for DECAY/SUSTAIN
- release_decr  input  32  unsigned; subtracted per step in RELEASE
- amp_in  input  32  signed oscillator sample
- amp_out  output  32  signed scaled sample, registered
- valid_out  output  1  one-cycle pulse, high the cycle after each step_in
- env_out  output  32  unsigned current envelope, registered
- busy_out  output  1  high whenever state is not IDLE

## Operation
- Full scale is ENV_MAX = 0xFFFFFFFF. State changes and env updates happen only on clock edges where step_in=1; otherwise all registers hold.
- States and per-step behaviour:
  - IDLE: env=0. Goes to ATTACK if gate_in=1.
  - ATTACK: env += attack_incr, saturating at ENV_MAX. Goes to DECAY on the step where env reaches ENV_MAX.
  - DECAY: env -= decay_decr, floored at sustain_level. Goes to SUSTAIN on the step where env reaches sustain_level.
  - SUSTAIN: env <= sustain_level on every step, so live changes to sustain_level track immediately.
  - RELEASE: env -= release_decr, floored at 0. Goes to IDLE on the step where env reaches 0. Goes to ATTACK if gate_in=1; the attack starts from the current env, with no reset to 0.
- Gate low in ATTACK, DECAY or SUSTAIN: go to RELEASE on that step. The gate check takes priority over the rate update: on that step env is decremented by release_decr, not by the old state's rate.
- Gate high while already in ATTACK, DECAY or SUSTAIN: no effect. A retrigger requires gate low on at least one step.
- Zero-rate rule: a rate input of 0 means "instant".
  - attack_incr=0: env=ENV_MAX in one step.
  - decay_decr=0: env=sustain_level in one step.
  - release_decr=0: env=0 in one step.
  - The normal transitions then apply.
- sustain_level=ENV_MAX: DECAY lasts exactly one step (env already at floor), then SUSTAIN.
- Saturation is computed in 33 bits. No wrap-around of env is ever permitted.
- Scaling:
  - The product is amp_in × signed({1'b0, env}), 65-bit signed.
  - amp_out = product[63:32], i.e. an arithmetic shift right by 32, which floors.
  - The env operand is the pre-update env (register value before this step's change).
  - The amp_in operand is as presented in the step_in cycle.

## Timing
- Reset: state=IDLE, env_out=0, amp_out=0, valid_out=0, busy_out=0. Reset mid-note discards state at the next edge; no release tail.
- env_out, state and amp_out all update on the step_in edge. valid_out is high in the following cycle.
- Latency: 1 clock from step_in to the new amp_out.
- The first nonzero amp_out appears on the second step after gate rises. The first step multiplies by env=0.
- busy_out reflects the registered state, so it rises the cycle after the gate step.
- Back-to-back step_in on consecutive cycles is supported: one state/env update per pulse.

## Structure
- Shared package synth_pkg:
  - env_state_t enum {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE}
  - ENV_MAX constant
  - SAMPLE_W=32 constant
- Single module with no sub-module. The next-env logic is one always_comb with saturating 33-bit add/sub. One registered 32×33 multiply feeds amp_out.

## Test plan
- Reset: hold rst_in with gate_in=1 and step pulses -> env_out=0, amp_out=0, busy_out=0 throughout.
- Attack/decay with attack_incr=0x40000000, decay_decr=0x20000000, sustain_level=0x80000000, gate high -> env sequence 0x40000000, 0x80000000, 0xC0000000, 0xFFFFFFFF (saturated, DECAY), 0xDFFFFFFF, 0xBFFFFFFF, 0x9FFFFFFF, 0x80000000 (SUSTAIN).
- Scaling: amp_in=0x40000000 with env=0x80000000 -> amp_out=0x20000000; amp_in=0x80000000 with env=ENV_MAX -> amp_out=0x80000000; valid_out pulses one cycle after each step.
- Release and retrigger: gate drops in SUSTAIN at 0x80000000 with release_decr=0x30000000 -> 0x50000000, 0x20000000, 0 (IDLE, busy_out low). A second run with gate raised at 0x20000000 -> ATTACK continues from 0x20000000 + attack_incr.
- Zero rates: attack_incr=0, decay_decr=0, release_decr=0 -> env jumps ENV_MAX, sustain_level, then 0 in single steps.
- Gate timing: gate pulses high and low between steps -> no state change. Live change of sustain_level in SUSTAIN -> env_out follows on the next step.
